lfsr_controller: RTL and testbench

- Control FSM sitting directly upstream of the LFSR datapath (pseudo_datapath) in the pseudo-random sequence generator.
- Drives every `*_en` / `*_s` control pair of that datapath and consumes its three status flags.
- On start it:
  1. loads the switch word,
  2. scans it bit-by-bit to pick up to two feedback taps,
  3. seeds the LFSR,
  4. steps it seq_num times,
  5. reports done.

---
 rtl/lfsr_pkg.sv | 31 +++
 rtl/lfsr_controller_if.sv | 48 ++++
 rtl/lfsr_controller_start_sync.sv | 35 +++
 rtl/lfsr_controller.sv | 157 +++++++++++++++
 tb/tb_lfsr_controller.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/lfsr_pkg.sv
// ============================================================================
// Module : lfsr_pkg
// Shared state encoding and constants for the LFSR sequence controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package lfsr_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    PRIME = 3'd2,
    SCAN  = 3'd3,
    SEED  = 3'd4,
    RUN   = 3'd5,
    DONE  = 3'd6
  } state_t;

  localparam logic [2:0] TAP0_DEFAULT = 3'd1;
  localparam logic [2:0] TAP1_DEFAULT = 3'd0;
  localparam int         SCAN_LEN     = 8;

  // Cycles spent outside IDLE for a run of the given length.
  function automatic int run_cycles(input int seq_num);
    return seq_num + SCAN_LEN + 6;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr_controller_if.sv
// ============================================================================
// Module : lfsr_controller_if
// Control/status bundle between the LFSR controller and its datapath.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface lfsr_controller_if;

  logic i_equals_8;
  logic switches0_equals_1;
  logic j_equals_seq_num;

  logic busy_en;
  logic busy_s;
  logic i_en;
  logic i_s;
  logic j_en;
  logic j_s;
  logic num_en;
  logic num_s;
  logic tap0_en;
  logic tap0_s;
  logic tap1_en;
  logic tap1_s;
  logic switches_en;
  logic switches_s;
  logic seq_num_en;
  logic seq_num_s;
  logic done;

  modport master (
    input  i_equals_8, switches0_equals_1, j_equals_seq_num,
    output busy_en, busy_s, i_en, i_s, j_en, j_s, num_en, num_s,
           tap0_en, tap0_s, tap1_en, tap1_s, switches_en, switches_s,
           seq_num_en, seq_num_s, done
  );

  modport slave (
    output i_equals_8, switches0_equals_1, j_equals_seq_num,
    input  busy_en, busy_s, i_en, i_s, j_en, j_s, num_en, num_s,
           tap0_en, tap0_s, tap1_en, tap1_s, switches_en, switches_s,
           seq_num_en, seq_num_s, done
  );

endinterface

`default_nettype wire

// File: rtl/lfsr_controller_start_sync.sv
// ============================================================================
// Module : start_sync
// Two-flop synchronizer followed by a rising-edge detector for a push-button.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module start_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  logic meta;
  logic sync;
  logic sync_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      meta   <= din;
      sync   <= meta;
      sync_d <= sync;
    end
  end

  assign pulse = sync & ~sync_d;

endmodule

`default_nettype wire

// File: rtl/lfsr_controller.sv
// ============================================================================
// Module : lfsr_controller
// Control FSM for the LFSR datapath: load, tap scan, seed, step, done.
// Optional macro LFSR_SINGLE_STEP_EN adds a step input gating RUN advances.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lfsr_controller
  import lfsr_pkg::*;
#(
  parameter bit SYNC_START = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
`ifdef LFSR_SINGLE_STEP_EN
  input  logic step,
`endif
  lfsr_controller_if.master dp
);

  state_t     state;
  state_t     state_next;
  logic [1:0] tap_cnt;
  logic [1:0] tap_cnt_next;
  logic       start_pulse;
  logic       step_ok;

  generate
    if (SYNC_START) begin : g_sync
      start_sync u_start_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (start),
        .pulse (start_pulse)
      );
    end else begin : g_direct
      assign start_pulse = start;
    end
  endgenerate

`ifdef LFSR_SINGLE_STEP_EN
  assign step_ok = step;
`else
  assign step_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      tap_cnt <= 2'd0;
    end else begin
      state   <= state_next;
      tap_cnt <= tap_cnt_next;
    end
  end

  always_comb begin
    state_next     = state;
    tap_cnt_next   = tap_cnt;
    dp.busy_en     = 1'b0;
    dp.busy_s      = 1'b0;
    dp.i_en        = 1'b0;
    dp.i_s         = 1'b0;
    dp.j_en        = 1'b0;
    dp.j_s         = 1'b0;
    dp.num_en      = 1'b0;
    dp.num_s       = 1'b0;
    dp.tap0_en     = 1'b0;
    dp.tap0_s      = 1'b0;
    dp.tap1_en     = 1'b0;
    dp.tap1_s      = 1'b0;
    dp.switches_en = 1'b0;
    dp.switches_s  = 1'b0;
    dp.seq_num_en  = 1'b0;
    dp.seq_num_s   = 1'b0;
    dp.done        = 1'b0;

    case (state)
      IDLE: begin
        // Clearing busy every idle cycle scrubs a stale value after reset.
        dp.busy_en = 1'b1;
        if (start_pulse) begin
          state_next = INIT;
        end
      end

      INIT: begin
        dp.switches_en = 1'b1;
        dp.i_en        = 1'b1;
        dp.tap0_en     = 1'b1;
        dp.tap1_en     = 1'b1;
        dp.busy_en     = 1'b1;
        dp.busy_s      = 1'b1;
        tap_cnt_next   = 2'd0;
        state_next     = PRIME;
      end

      PRIME: begin
        dp.i_en    = 1'b1;
        dp.i_s     = 1'b1;
        state_next = SCAN;
      end

      SCAN: begin
        if (dp.i_equals_8) begin
          state_next = SEED;
        end else begin
          dp.i_en        = 1'b1;
          dp.i_s         = 1'b1;
          dp.switches_en = 1'b1;
          dp.switches_s  = 1'b1;
          if (dp.switches0_equals_1 && (tap_cnt == 2'd0)) begin
            dp.tap0_en   = 1'b1;
            dp.tap0_s    = 1'b1;
            tap_cnt_next = 2'd1;
          end else if (dp.switches0_equals_1 && (tap_cnt == 2'd1)) begin
            dp.tap1_en   = 1'b1;
            dp.tap1_s    = 1'b1;
            tap_cnt_next = 2'd2;
          end
        end
      end

      SEED: begin
        dp.num_en  = 1'b1;
        dp.j_en    = 1'b1;
        state_next = RUN;
      end

      RUN: begin
        if (dp.j_equals_seq_num) begin
          state_next = DONE;
        end else if (step_ok) begin
          dp.num_en = 1'b1;
          dp.num_s  = 1'b1;
          dp.j_en   = 1'b1;
          dp.j_s    = 1'b1;
        end
      end

      DONE: begin
        dp.done    = 1'b1;
        dp.busy_en = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_lfsr_controller.sv
// ============================================================================
// Module : tb_lfsr_controller
// Directed bench: controller coupled to a behavioural LFSR datapath.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lfsr_controller;

  logic clk;
  logic rst_n;
  logic start;
`ifdef LFSR_SINGLE_STEP_EN
  logic step;
`endif

  lfsr_controller_if dp_if ();

  lfsr_controller u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
`ifdef LFSR_SINGLE_STEP_EN
    .step  (step),
`endif
    .dp    (dp_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath model
  logic       busy_m;
  logic [3:0] i_m;
  logic [7:0] j_m;
  logic [7:0] num_m;
  logic [2:0] tap0_m;
  logic [2:0] tap1_m;
  logic [7:0] sw_m;
  logic [7:0] sw_in;
  logic [7:0] seq_val;

  assign dp_if.i_equals_8         = (i_m == 4'd8);
  assign dp_if.switches0_equals_1 = sw_m[0];
  assign dp_if.j_equals_seq_num   = (j_m == seq_val);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_m <= 1'b1;
      i_m    <= 4'd0;
      j_m    <= 8'd0;
      num_m  <= 8'd0;
      tap0_m <= 3'd0;
      tap1_m <= 3'd0;
      sw_m   <= 8'd0;
    end else begin
      if (dp_if.busy_en)     busy_m <= dp_if.busy_s;
      if (dp_if.i_en)        i_m    <= dp_if.i_s ? i_m + 4'd1 : 4'hF;
      if (dp_if.j_en)        j_m    <= dp_if.j_s ? j_m + 8'd1 : 8'd0;
      if (dp_if.num_en)      num_m  <= dp_if.num_s ? {num_m[6:0], num_m[tap0_m] ^ num_m[tap1_m]} : 8'h01;
      if (dp_if.tap0_en)     tap0_m <= dp_if.tap0_s ? i_m[2:0] : 3'd1;
      if (dp_if.tap1_en)     tap1_m <= dp_if.tap1_s ? i_m[2:0] : 3'd0;
      if (dp_if.switches_en) sw_m   <= dp_if.switches_s ? (sw_m >> 1) : sw_in;
    end
  end

  int checks;
  int passed;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] ctl_vec();
    return {dp_if.busy_en, dp_if.busy_s, dp_if.i_en, dp_if.i_s, dp_if.j_en, dp_if.j_s,
            dp_if.num_en, dp_if.num_s, dp_if.tap0_en, dp_if.tap0_s, dp_if.tap1_en,
            dp_if.tap1_s, dp_if.switches_en, dp_if.switches_s, dp_if.seq_num_en,
            dp_if.seq_num_s, dp_if.done};
  endfunction

  // Pulses start, then follows the run at negedges. cnt is 1 in the INIT
  // cycle; mask bit k re-drives start while cnt==k; abort_at asserts reset.
  task automatic run_case(input logic [7:0] sw, input logic [7:0] seq,
                          input logic [31:0] mask, input int abort_at,
                          output int cycles, output int caps,
                          output int dones, output int inits_after);
    int cnt;
    bit fin;
    cycles = 0; caps = 0; dones = 0; inits_after = 0; cnt = 0; fin = 1'b0;
    sw_in   = sw;
    seq_val = seq;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    for (int k = 0; k < 200 && !fin; k++) begin
      if (dp_if.busy_en && dp_if.busy_s) cnt = 1;
      else if (cnt > 0) cnt++;
      if ((dp_if.tap0_en && dp_if.tap0_s) || (dp_if.tap1_en && dp_if.tap1_s)) caps++;
      if (dp_if.done) begin
        dones++;
        cycles = cnt;
        fin    = 1'b1;
      end else if (abort_at > 0 && cnt == abort_at) begin
        rst_n = 1'b0;
        fin   = 1'b1;
      end else begin
        start = (cnt > 0 && cnt < 32) ? mask[cnt] : 1'b0;
        @(negedge clk);
      end
    end
    start = 1'b0;
    check("run_finished", {31'd0, fin}, 32'd1);
    if (abort_at == 0) begin
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        if (dp_if.done) dones++;
        if (dp_if.busy_en && dp_if.busy_s) inits_after++;
      end
    end
  endtask

  int cyc, caps, dones, inits;

  initial begin
    checks  = 0;
    passed  = 0;
    rst_n   = 1'b0;
    start   = 1'b0;
    sw_in   = 8'h00;
    seq_val = 8'h00;
`ifdef LFSR_SINGLE_STEP_EN
    step    = 1'b1;
`endif
    repeat (3) @(negedge clk);
    check("rst_ctl", {15'd0, ctl_vec()}, 32'h10000);
    check("rst_busy_stale", {31'd0, busy_m}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_clears_busy", {31'd0, busy_m}, 32'd0);
    repeat (2) @(negedge clk);

    // Two taps at the extremes of the switch word
    run_case(8'h81, 8'd3, 32'd0, 0, cyc, caps, dones, inits);
    check("a_tap0", {29'd0, tap0_m}, 32'd0);
    check("a_tap1", {29'd0, tap1_m}, 32'd7);
    check("a_num", {24'd0, num_m}, 32'h0F);
    check("a_cycles", cyc, 32'd17);
    check("a_caps", caps, 32'd2);
    check("a_done_once", dones, 32'd1);
    check("a_busy", {31'd0, busy_m}, 32'd0);

    // No set bits: default taps
    run_case(8'h00, 8'd2, 32'd0, 0, cyc, caps, dones, inits);
    check("b_tap0", {29'd0, tap0_m}, 32'd1);
    check("b_tap1", {29'd0, tap1_m}, 32'd0);
    check("b_num", {24'd0, num_m}, 32'h06);
    check("b_caps", caps, 32'd0);
    check("b_cycles", cyc, 32'd16);
    check("b_busy", {31'd0, busy_m}, 32'd0);

    // Third set bit ignored
    run_case(8'h0E, 8'd2, 32'd0, 0, cyc, caps, dones, inits);
    check("c_tap0", {29'd0, tap0_m}, 32'd1);
    check("c_tap1", {29'd0, tap1_m}, 32'd2);
    check("c_caps", caps, 32'd2);
    check("c_num", {24'd0, num_m}, 32'h05);

    // Zero-length run
    run_case(8'h81, 8'd0, 32'd0, 0, cyc, caps, dones, inits);
    check("d_num", {24'd0, num_m}, 32'h01);
    check("d_cycles", cyc, 32'd14);
    check("d_done_once", dones, 32'd1);

    // Start re-pressed during SCAN and RUN
    run_case(8'h81, 8'd3, (32'd1 << 4) | (32'd1 << 13), 0, cyc, caps, dones, inits);
    check("e_num", {24'd0, num_m}, 32'h0F);
    check("e_cycles", cyc, 32'd17);
    check("e_tap1", {29'd0, tap1_m}, 32'd7);
    check("e_no_restart", inits, 32'd0);
    check("e_done_once", dones, 32'd1);

    // Reset in the middle of RUN, then a clean run
    run_case(8'h81, 8'd3, 32'd0, 13, cyc, caps, dones, inits);
    #1;
    check("f_rst_ctl", {15'd0, ctl_vec()}, 32'h10000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("f_busy_cleared", {31'd0, busy_m}, 32'd0);
    run_case(8'h81, 8'd3, 32'd0, 0, cyc, caps, dones, inits);
    check("f_num", {24'd0, num_m}, 32'h0F);
    check("f_cycles", cyc, 32'd17);
    check("f_done_once", dones, 32'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
